// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
// Receive-side UART deframer. Oversamples the serial line with BaudTick and
// detects the start bit. It then shifts in 7 or 8 data bits, an optional
// parity bit and 1 or 2 stop bits. The recovered byte is presented together
// with parity and stop status.
//
// Ports:
//   Clock       system clock, rising edge
//   Reset       asynchronous, active-low reset
//   BaudTick    one-Clock enable at OVERSAMPLE x baud rate
//   RxIn        raw serial line (idle high, asynchronous)
//   ParityType  00/11 none, 01 odd, 10 even (latched at start)
//   StopBits    0: one stop bit, 1: two stop bits (latched at start)
//   DataLength  0: 7 data bits, 1: 8 data bits (latched at start)
//   DataOut     received byte, bit7=0 in 7-bit mode
//   DataValid   one-Clock pulse per completed frame
//   ParityError parity mismatch in the frame flagged by DataValid
//   StopError   a stop bit was sampled low
//   Busy        high from start detection until back in IDLE
//
// Optional build macro RX_MAJORITY_VOTE_EN: each bit value is the 2-of-3
// majority of the last three tick samples. The window ends on the tick where
// the single-sample build decides, so frame timing is the same in both builds.
//
// State | meaning
// IDLE  | waiting for rx_s low on a tick
// START | validating the start bit at mid-bit
// DATA  | sampling 7/8 data bits at bit centre
// PARITY| sampling the parity bit
// STOP  | sampling 1/2 stop bits
// DONE  | presenting the frame for one Clock

module uart_rx_deframer #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 5
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       BaudTick,
  input  logic       RxIn,
  input  logic [1:0] ParityType,
  input  logic       StopBits,
  input  logic       DataLength,
  output logic [7:0] DataOut,
  output logic       DataValid,
  output logic       ParityError,
  output logic       StopError,
  output logic       Busy
);

  localparam logic [CNT_W-1:0] START_MID = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  state_t           state_q;
  logic             rx_meta_q, rx_s_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic [1:0]       cfg_par_q;
  logic             cfg_stop2_q, cfg_len8_q;
  logic             par_acc_q, par_err_q, stop_err_q;
  logic [7:0]       data_out_q;
  logic             data_valid_q, parity_error_q, stop_error_q, busy_q;
  logic             bit_d;
  logic             par_en_d;
  logic [CNT_W-1:0] cnt_inc_d;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RxIn;
      rx_s_q    <= rx_meta_q;
    end
  end

`ifdef RX_MAJORITY_VOTE_EN
  // hist_q[0]/[1] hold rx_s from one and two ticks ago.
  logic [1:0] hist_q;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      hist_q <= 2'b11;
    end else if (BaudTick) begin
      hist_q <= {hist_q[0], rx_s_q};
    end
  end

  assign bit_d = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
  assign bit_d = rx_s_q;
`endif

  assign par_en_d  = cfg_par_q[1] ^ cfg_par_q[0];
  assign cnt_inc_d = cnt_q + CNT_W'(1);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      cfg_par_q      <= '0;
      cfg_stop2_q    <= 1'b0;
      cfg_len8_q     <= 1'b0;
      par_acc_q      <= 1'b0;
      par_err_q      <= 1'b0;
      stop_err_q     <= 1'b0;
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      if (state_q == S_DONE) begin
        // Busy stays high in the DataValid cycle and drops on the next IDLE clock.
        data_valid_q   <= 1'b1;
        data_out_q     <= cfg_len8_q ? shift_q : {1'b0, shift_q[7:1]};
        parity_error_q <= par_err_q;
        stop_error_q   <= stop_err_q;
        state_q        <= S_IDLE;
      end else if (BaudTick) begin
        case (state_q)
          S_IDLE: begin
            if (!rx_s_q) begin
              state_q     <= S_START;
              busy_q      <= 1'b1;
              cnt_q       <= '0;
              bit_cnt_q   <= '0;
              par_acc_q   <= 1'b0;
              par_err_q   <= 1'b0;
              stop_err_q  <= 1'b0;
              cfg_par_q   <= ParityType;
              cfg_stop2_q <= StopBits;
              cfg_len8_q  <= DataLength;
            end else begin
              busy_q <= 1'b0;
            end
          end
          S_START: begin
            if (cnt_q == START_MID) begin
              cnt_q <= '0;
              if (bit_d) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end else begin
                state_q <= S_DATA;
              end
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end
          S_DATA: begin
            if (cnt_q == BIT_END) begin
              cnt_q     <= '0;
              shift_q   <= {bit_d, shift_q[7:1]};
              par_acc_q <= par_acc_q ^ bit_d;
              if (bit_cnt_q == {2'b11, cfg_len8_q}) begin
                bit_cnt_q <= '0;
                state_q   <= par_en_d ? S_PARITY : S_STOP;
              end else begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end
          S_PARITY: begin
            if (cnt_q == BIT_END) begin
              cnt_q <= '0;
              // cfg_par_q[0] set means odd: total ones must be odd.
              par_err_q <= (par_acc_q ^ bit_d) ^ cfg_par_q[0];
              state_q   <= S_STOP;
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end
          S_STOP: begin
            if (cnt_q == BIT_END) begin
              cnt_q <= '0;
              if (!bit_d) stop_err_q <= 1'b1;
              if (!cfg_stop2_q || bit_cnt_q[0]) begin
                state_q <= S_DONE;
              end else begin
                bit_cnt_q <= 3'd1;
              end
            end else begin
              cnt_q <= cnt_inc_d;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (state_q == S_IDLE) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign DataOut     = data_out_q;
  assign DataValid   = data_valid_q;
  assign ParityError = parity_error_q;
  assign StopError   = stop_error_q;
  assign Busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Testbench for uart_rx_deframer: frames are built bit by bit from their
// configuration. Expected byte, flags and DataValid tick are queued per frame.
// A negedge monitor checks every cycle against that queue and the held values.
module tb_uart_rx_deframer;

  localparam int OS = 16;

  logic       Clock, Reset, BaudTick, RxIn;
  logic [1:0] ParityType;
  logic       StopBits, DataLength;
  logic [7:0] DataOut;
  logic       DataValid, ParityError, StopError, Busy;

  uart_rx_deframer #(.OVERSAMPLE(OS), .CNT_W(5)) dut (
    .Clock(Clock), .Reset(Reset), .BaudTick(BaudTick), .RxIn(RxIn),
    .ParityType(ParityType), .StopBits(StopBits), .DataLength(DataLength),
    .DataOut(DataOut), .DataValid(DataValid), .ParityError(ParityError),
    .StopError(StopError), .Busy(Busy)
  );

  typedef struct {
    logic [7:0] data;
    bit         pe;
    bit         se;
    int         tick;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         tick_cnt = 0;
  int         valid_cnt = 0;
  logic [7:0] hold_data = 8'h00;
  bit         hold_pe = 0, hold_se = 0, busy_chk = 0;

  initial begin
    Clock = 0;
    forever #5 Clock = ~Clock;
  end

  // BaudTick every 4th Clock.
  initial begin
    BaudTick = 0;
    forever begin
      repeat (3) @(posedge Clock);
      #1 BaudTick = 1;
      @(posedge Clock);
      #1 BaudTick = 0;
    end
  end

  always @(posedge Clock) if (BaudTick) tick_cnt <= tick_cnt + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (!Reset) begin
        hold_data = 8'h00; hold_pe = 0; hold_se = 0; busy_chk = 0;
        chk("reset_outputs", {DataOut, DataValid, ParityError, StopError, Busy}, 32'h0);
      end else begin
        if (busy_chk) begin
          chk("busy_after_valid", Busy, 1'b0);
          busy_chk = 0;
        end
        if (DataValid) begin
          valid_cnt++;
          busy_chk = 1;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_valid: got DataOut %0h with no frame pending", DataOut);
          end else begin
            e = exp_q.pop_front();
            chk("frame_data", DataOut, e.data);
            chk("frame_parity_err", ParityError, e.pe);
            chk("frame_stop_err", StopError, e.se);
            chk("frame_valid_tick", tick_cnt, e.tick);
          end
          hold_data = DataOut; hold_pe = ParityError; hold_se = StopError;
        end else begin
          chk("hold_outputs", {DataOut, ParityError, StopError}, {hold_data, hold_pe, hold_se});
        end
      end
    end
  end

  task automatic wait_tick;
    do @(posedge Clock); while (BaudTick !== 1'b1);
    #2;
  endtask

  task automatic idle(input int n);
    RxIn = 1'b1;
    repeat (n) wait_tick();
  endtask

  // Drive one frame slot by slot (OS ticks per bit). glitch_k inverts the line
  // for a single tick at frame tick glitch_k; abort_k stops driving there and
  // the frame is not expected to complete.
  task automatic send_frame(input logic [7:0] data, input bit len8, input logic [1:0] ptype,
                            input bit stop2, input int par_force, input bit stop_low,
                            input int glitch_k, input int abort_k);
    logic bits[$];
    int   nd, k, gb;
    bit   par_en;
    logic pbit;
    logic [7:0] expd;
    exp_t e;
    nd     = len8 ? 8 : 7;
    par_en = (ptype == 2'b01) || (ptype == 2'b10);
    expd   = len8 ? data : {1'b0, data[6:0]};
    pbit   = (ptype == 2'b01) ? ~(^expd) : (^expd);
    if (par_force >= 0) pbit = par_force[0];
    bits.push_back(1'b0);
    for (int i = 0; i < nd; i++) bits.push_back(data[i]);
    if (par_en) bits.push_back(pbit);
    bits.push_back(~stop_low);
    if (stop2) bits.push_back(1'b1);
`ifndef RX_MAJORITY_VOTE_EN
    // A single-sample receiver takes the glitch if it lands on a data bit centre.
    gb = glitch_k / OS;
    if (glitch_k >= 0 && (glitch_k % OS) == OS / 2 && gb >= 1 && gb <= nd)
      expd[gb - 1] = ~expd[gb - 1];
`endif
    e.data = expd;
    e.pe   = par_en && ((($countones(expd) + int'(pbit)) % 2) != ((ptype == 2'b01) ? 1 : 0));
    e.se   = stop_low;
    e.tick = tick_cnt + 1 + OS / 2 + (bits.size() - 1) * OS;
    if (abort_k < 0) exp_q.push_back(e);
    ParityType = ptype; StopBits = stop2; DataLength = len8;
    for (int b = 0; b < bits.size(); b++) begin
      for (int j = 0; j < OS; j++) begin
        k = b * OS + j;
        if (k == abort_k) return;
        // Configuration changes after the start bit must be ignored.
        if (k == OS) begin
          ParityType = ~ptype; StopBits = ~stop2; DataLength = ~len8;
        end
        RxIn = (k == glitch_k) ? ~bits[b] : bits[b];
        wait_tick();
      end
    end
  endtask

  initial begin
    int vbefore;
    Reset = 0; RxIn = 1; ParityType = 2'b00; StopBits = 0; DataLength = 1;
    repeat (5) @(posedge Clock);
    #2 Reset = 1;
    idle(4);

    // 8N1 0xA5
    send_frame(8'hA5, 1, 2'b00, 0, -1, 0, -1, -1);
    chk("a5_data", DataOut, 8'hA5);
    chk("a5_flags", {ParityError, StopError}, 2'b00);
    idle(4);

    // 7E2 0x35, correct parity then parity forced to 1
    send_frame(8'h35, 0, 2'b10, 1, -1, 0, -1, -1);
    chk("7e2_data", DataOut, 8'h35);
    chk("7e2_pe0", ParityError, 1'b0);
    idle(4);
    send_frame(8'h35, 0, 2'b10, 1, 1, 0, -1, -1);
    chk("7e2_bad_data", DataOut, 8'h35);
    chk("7e2_pe1", ParityError, 1'b1);
    idle(4);

    // 8O1 0xFF with low stop bit; the held-low line then causes a false start
    send_frame(8'hFF, 1, 2'b01, 0, -1, 1, -1, -1);
    chk("8o1_data", DataOut, 8'hFF);
    chk("8o1_flags", {ParityError, StopError}, 2'b01);
    idle(2 * OS);

    // 4-tick low pulse from idle
    vbefore = valid_cnt;
    RxIn = 0;
    repeat (4) wait_tick();
    chk("false_start_busy_hi", Busy, 1'b1);
    RxIn = 1;
    repeat (6) wait_tick();
    chk("false_start_busy_lo", Busy, 1'b0);
    chk("false_start_no_valid", valid_cnt - vbefore, 0);
    idle(4);

    // Reset during data bit 3 of 0x5A, then 0x3C
    vbefore = valid_cnt;
    send_frame(8'h5A, 1, 2'b00, 0, -1, 0, -1, 4 * OS + OS / 2);
    RxIn = 1;
    Reset = 0;
    repeat (6) @(posedge Clock);
    chk("reset_mid_data", DataOut, 8'h00);
    #2 Reset = 1;
    idle(8);
    send_frame(8'h3C, 1, 2'b00, 0, -1, 0, -1, -1);
    chk("after_reset_data", DataOut, 8'h3C);
    chk("after_reset_one_valid", valid_cnt - vbefore, 1);
    idle(4);

    // Back-to-back 8N1
    send_frame(8'h01, 1, 2'b00, 0, -1, 0, -1, -1);
    chk("b2b_first", DataOut, 8'h01);
    send_frame(8'h80, 1, 2'b00, 0, -1, 0, -1, -1);
    chk("b2b_second", DataOut, 8'h80);
    idle(4);

    // One-tick high glitch at the centre of data bit 4 of 0x80
    send_frame(8'h80, 1, 2'b00, 0, -1, 0, 5 * OS + OS / 2, -1);
`ifdef RX_MAJORITY_VOTE_EN
    chk("glitch_data", DataOut, 8'h80);
`else
    chk("glitch_data", DataOut, 8'h90);
`endif
    idle(2 * OS);

    chk("queue_drained", exp_q.size(), 0);
    chk("total_valids", valid_cnt, 8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
